// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle MIPS control sequencer with retired-instruction counter.
// Optional 7-segment state mnemonic display: define CTRL_SEG_DISPLAY_EN.
module multicycle_ctrl_fsm #(
  parameter int CNT_W        = 16,
  parameter int ILLEGAL_HALT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_en,
  output logic [1:0]       pc_source,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic [3:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] retire_cnt
`ifdef CTRL_SEG_DISPLAY_EN
  ,
  output logic [6:0]       seg_first,
  output logic [6:0]       seg_second
`endif
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    REX    = 4'd6,
    RWB    = 4'd7,
    BR     = 4'd8,
    JMP    = 4'd9,
    IEX    = 4'd10,
    IWB    = 4'd11,
    HALT   = 4'd15
  } state_t;

  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q;

  logic rd_s, wr_s, irw_s, pce_s, rw_s;
  logic halt_s;

  logic is_r, is_lw, is_sw, is_beq, is_bne;
  logic is_j, is_addi, is_andi;

  assign is_r    = (opcode == 6'b000000);
  assign is_lw   = (opcode == 6'b100011);
  assign is_sw   = (opcode == 6'b101011);
  assign is_beq  = (opcode == 6'b000100);
  assign is_bne  = (opcode == 6'b000101);
  assign is_j    = (opcode == 6'b000010);
  assign is_addi = (opcode == 6'b001000);
  assign is_andi = (opcode == 6'b001100);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q != FETCH && state_d == FETCH)
        cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    state_d    = state_q;
    rd_s       = 1'b0;
    wr_s       = 1'b0;
    irw_s      = 1'b0;
    pce_s      = 1'b0;
    rw_s       = 1'b0;
    halt_s     = 1'b0;
    iord       = 1'b0;
    pc_source  = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    unique case (state_q)
      FETCH: begin
        rd_s      = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          irw_s   = 1'b1;
          pce_s   = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        alu_src_b = 2'b11;
        unique case (1'b1)
          is_r:              state_d = REX;
          is_lw, is_sw:      state_d = MEMADR;
          is_beq, is_bne:    state_d = BR;
          is_j:              state_d = JMP;
          is_addi, is_andi:  state_d = IEX;
          default:
            state_d = (ILLEGAL_HALT != 0) ? HALT : FETCH;
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = is_sw ? MEMWR : MEMRD;
      end
      MEMRD: begin
        rd_s = 1'b1;
        iord = 1'b1;
        if (mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        rw_s       = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = FETCH;
      end
      MEMWR: begin
        wr_s = 1'b1;
        iord = 1'b1;
        if (mem_ready) state_d = FETCH;
      end
      REX: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = RWB;
      end
      RWB: begin
        rw_s    = 1'b1;
        reg_dst = 1'b1;
        state_d = FETCH;
      end
      BR: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_source = 2'b01;
        pce_s     = zero ^ is_bne;
        state_d   = FETCH;
      end
      JMP: begin
        pc_source = 2'b10;
        pce_s     = 1'b1;
        state_d   = FETCH;
      end
      IEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = is_andi ? 2'b11 : 2'b00;
        state_d   = IWB;
      end
      IWB: begin
        rw_s    = 1'b1;
        state_d = FETCH;
      end
      HALT: begin
        halt_s = 1'b1;
      end
      default: begin
        halt_s  = 1'b1;
        state_d = HALT;
      end
    endcase
  end

  // strobes are killed combinationally so an abort is immediate
  assign mem_read   = rd_s  & rst_n;
  assign mem_write  = wr_s  & rst_n;
  assign ir_write   = irw_s & rst_n;
  assign pc_en      = pce_s & rst_n;
  assign reg_write  = rw_s  & rst_n;
  assign halted     = halt_s;
  assign state      = state_q;
  assign retire_cnt = cnt_q;

`ifdef CTRL_SEG_DISPLAY_EN
  // glyphs are active-high {g,f,e,d,c,b,a}; ports are inverted
  localparam logic [6:0] G_I = 7'b0000110;
  localparam logic [6:0] G_F = 7'b1110001;
  localparam logic [6:0] G_i = 7'b0000100;
  localparam logic [6:0] G_d = 7'b1011110;
  localparam logic [6:0] G_E = 7'b1111001;
  localparam logic [6:0] G_X = 7'b1110110;
  localparam logic [6:0] G_M = 7'b0110111;
  localparam logic [6:0] G_A = 7'b1110111;
  localparam logic [6:0] G_W = 7'b0111110;
  localparam logic [6:0] G_b = 7'b1111100;
  localparam logic [6:0] G_r = 7'b1010000;
  localparam logic [6:0] G_J = 7'b0011110;
  localparam logic [6:0] G_H = 7'b1110110;
  localparam logic [6:0] G_L = 7'b0111000;
  localparam logic [6:0] G_0 = 7'b0000000;

  logic [13:0] glyph;

  always_comb begin
    glyph = {G_0, G_0};
    unique case (state_q)
      FETCH:             glyph = {G_I, G_F};
      DECODE:            glyph = {G_i, G_d};
      MEMADR, REX, IEX:  glyph = {G_E, G_X};
      MEMRD, MEMWR:      glyph = {G_M, G_A};
      MEMWB, RWB, IWB:   glyph = {G_W, G_b};
      BR:                glyph = {G_b, G_r};
      JMP:               glyph = {G_J, G_0};
      HALT:              glyph = {G_H, G_L};
      default:           glyph = {G_0, G_0};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_first  <= 7'b1111111;
      seg_second <= 7'b1111111;
    end else begin
      seg_first  <= ~glyph[13:7];
      seg_second <= ~glyph[6:0];
    end
  end
`endif

endmodule
